semaforo_param: RTL and testbench

SEMAFORO_PARAM -- requirements
Module: semaforo_param

---
 rtl/semaforo_pkg.sv | 19 +
 rtl/semaforo_timer.sv | 34 +++
 rtl/semaforo_param.sv | 167 ++++++++++++++++
 tb/tb_semaforo_param.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared types and default timing for the round-robin traffic-light controller.
package semaforo_pkg;

    typedef enum logic [1:0] {
        ST_GREEN,
        ST_YELLOW,
        ST_ALLRED,
        ST_FLASH
    } state_e;

    localparam int DEF_N_WAYS      = 2;
    localparam int DEF_CNT_W       = 5;
    localparam int DEF_T_GREEN     = 20;
    localparam int DEF_T_GREEN_MIN = 10;
    localparam int DEF_T_YELLOW    = 11;
    localparam int DEF_T_ALLRED    = 2;
    localparam int DEF_T_FLASH     = 8;

endpackage

// File: rtl/semaforo_timer.sv
// Phase counter: counts up from 0, synchronous clear, terminal-count compare
// against a per-state limit (limit = phase length - 1).
module semaforo_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: restart on clear, otherwise advance by one.
    always_comb begin
        count_d = clr ? '0 : count_q + CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == limit);

endmodule

// File: rtl/semaforo_param.sv
// Round-robin traffic-light controller with request-shortened green,
// yellow and all-red clearance, plus a flashing-yellow night/fault mode.
module semaforo_param
    import semaforo_pkg::*;
#(
    parameter int N_WAYS      = DEF_N_WAYS,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int T_GREEN     = DEF_T_GREEN,
    parameter int T_GREEN_MIN = DEF_T_GREEN_MIN,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_ALLRED    = DEF_T_ALLRED,
    parameter int T_FLASH     = DEF_T_FLASH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_WAYS-1:0]         btn,
    input  logic                      mode_flash,
    output logic [N_WAYS-1:0]         green,
    output logic [N_WAYS-1:0]         yellow,
    output logic [N_WAYS-1:0]         red,
    output logic [$clog2(N_WAYS)-1:0] phase
);

    localparam int PW = $clog2(N_WAYS);

    if (N_WAYS < 2) begin : g_bad_ways
        $error("semaforo_param: N_WAYS must be at least 2");
    end
    if (T_GREEN < 1 || T_GREEN_MIN < 1 || T_YELLOW < 1 || T_ALLRED < 1 || T_FLASH < 1) begin : g_bad_min
        $error("semaforo_param: every phase length must be at least 1");
    end
    if (T_GREEN_MIN > T_GREEN) begin : g_bad_gmin
        $error("semaforo_param: T_GREEN_MIN exceeds T_GREEN");
    end
    if (T_GREEN > 2**CNT_W || T_GREEN_MIN > 2**CNT_W || T_YELLOW > 2**CNT_W ||
        T_ALLRED > 2**CNT_W || T_FLASH > 2**CNT_W) begin : g_bad_width
        $error("semaforo_param: a phase length does not fit the counter width");
    end

    state_e            state_q, state_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [N_WAYS-1:0] req_q, req_d;
    logic              flash_on_q, flash_on_d;
    logic [N_WAYS-1:0] green_q, green_d;
    logic [N_WAYS-1:0] yellow_q, yellow_d;
    logic [N_WAYS-1:0] red_q, red_d;
    logic [N_WAYS-1:0] mask_q, mask_d;

    logic [CNT_W-1:0]  limit;
    logic [CNT_W-1:0]  count;
    logic              tc;
    logic              clr;

    // Terminal count for the state currently being timed.
    always_comb begin
        limit = CNT_W'(T_ALLRED - 1);
        unique case (state_q)
            ST_GREEN:  limit = CNT_W'(T_GREEN - 1);
            ST_YELLOW: limit = CNT_W'(T_YELLOW - 1);
            ST_ALLRED: limit = CNT_W'(T_ALLRED - 1);
            ST_FLASH:  limit = CNT_W'(T_FLASH - 1);
            default:   limit = CNT_W'(T_ALLRED - 1);
        endcase
    end

    semaforo_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .limit (limit),
        .count (count),
        .tc    (tc)
    );

    // Next state, phase, request latches and registered lamp values.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        flash_on_d = flash_on_q;

        mask_q = N_WAYS'(1) << phase_q;

        unique case (state_q)
            ST_GREEN: begin
                if (mode_flash || tc ||
                    ((count >= CNT_W'(T_GREEN_MIN - 1)) && (|(req_q & ~mask_q)))) begin
                    state_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (tc) begin
                    state_d = ST_ALLRED;
                end
            end
            ST_ALLRED: begin
                if (tc) begin
                    if (mode_flash) begin
                        state_d    = ST_FLASH;
                        flash_on_d = 1'b1;
                    end else begin
                        state_d = ST_GREEN;
                        phase_d = (phase_q == PW'(N_WAYS - 1)) ? '0 : phase_q + PW'(1);
                    end
                end
            end
            ST_FLASH: begin
                if (!mode_flash) begin
                    state_d = ST_ALLRED;
                end else if (tc) begin
                    flash_on_d = ~flash_on_q;
                end
            end
            default: state_d = ST_ALLRED;
        endcase

        mask_d = N_WAYS'(1) << phase_d;

        // Flash half-periods reuse the counter, so it restarts on each toggle
        // as well as on every state change.
        clr = (state_d != state_q) || ((state_q == ST_FLASH) && tc);

        // The serving approach's own button is ignored while it is green;
        // entering green for an approach clears its latch even if pressed now.
        req_d = req_q | (btn & ~((state_q == ST_GREEN) ? mask_q : '0));
        if ((state_d == ST_GREEN) && (state_q != ST_GREEN)) begin
            req_d = req_d & ~mask_d;
        end

        green_d  = (state_d == ST_GREEN) ? mask_d : '0;
        yellow_d = '0;
        if (state_d == ST_YELLOW) begin
            yellow_d = mask_d;
        end else if (state_d == ST_FLASH) begin
            yellow_d = {N_WAYS{flash_on_d}};
        end
        red_d = (state_d == ST_FLASH) ? '0 : ~(green_d | yellow_d);
    end

    // State, phase, request and lamp registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ALLRED;
            phase_q    <= PW'(N_WAYS - 1);
            req_q      <= '0;
            flash_on_q <= 1'b0;
            green_q    <= '0;
            yellow_q   <= '0;
            red_q      <= '1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            req_q      <= req_d;
            flash_on_q <= flash_on_d;
            green_q    <= green_d;
            yellow_q   <= yellow_d;
            red_q      <= red_d;
        end
    end

    assign green  = green_q;
    assign yellow = yellow_q;
    assign red    = red_q;
    assign phase  = phase_q;

endmodule

// File: tb/tb_semaforo_param.sv
// Self-checking bench for semaforo_param: directed lamp-sequence scenarios
// plus randomized buttons / flash mode against a behavioural timing model.
module tb_semaforo_param;

    localparam int N   = 2;
    localparam int CW  = 5;
    localparam int TG  = 20;
    localparam int TGM = 10;
    localparam int TY  = 11;
    localparam int TAR = 2;
    localparam int TF  = 8;

    localparam int S_GREEN  = 0;
    localparam int S_YELLOW = 1;
    localparam int S_ALLRED = 2;
    localparam int S_FLASH  = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [N-1:0]         btn = '0;
    logic                 mode_flash = 1'b0;
    logic [N-1:0]         green;
    logic [N-1:0]         yellow;
    logic [N-1:0]         red;
    logic [$clog2(N)-1:0] phase;

    semaforo_param #(
        .N_WAYS      (N),
        .CNT_W       (CW),
        .T_GREEN     (TG),
        .T_GREEN_MIN (TGM),
        .T_YELLOW    (TY),
        .T_ALLRED    (TAR),
        .T_FLASH     (TF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .mode_flash (mode_flash),
        .green      (green),
        .yellow     (yellow),
        .red        (red),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: which lamp state is showing, how many cycles it has
    // been shown, the active approach and the pending requests.
    int m_st;
    int m_done;
    int m_ph;
    bit m_req [N];

    task automatic model_reset();
        m_st   = S_ALLRED;
        m_done = 0;
        m_ph   = N - 1;
        for (int i = 0; i < N; i++) m_req[i] = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] b, input logic mf);
        int fin;
        int nst;
        int nph;
        bit others;
        fin    = m_done + 1;
        nst    = m_st;
        nph    = m_ph;
        others = 1'b0;
        for (int i = 0; i < N; i++) if (i != m_ph && m_req[i]) others = 1'b1;
        case (m_st)
            S_GREEN:  if (mf || fin >= TG || (fin >= TGM && others)) nst = S_YELLOW;
            S_YELLOW: if (fin >= TY) nst = S_ALLRED;
            S_ALLRED: if (fin >= TAR) begin
                if (mf) nst = S_FLASH;
                else begin
                    nst = S_GREEN;
                    nph = (m_ph + 1) % N;
                end
            end
            default:  if (!mf) nst = S_ALLRED;
        endcase
        for (int i = 0; i < N; i++)
            if (b[i] && !(m_st == S_GREEN && i == m_ph)) m_req[i] = 1'b1;
        if (nst == S_GREEN && m_st != S_GREEN) m_req[nph] = 1'b0;
        m_done = (nst == m_st) ? fin : 0;
        m_st   = nst;
        m_ph   = nph;
    endtask

    // Run-length record of the lamp pattern, for duration checks.
    int             run_len[$];
    logic [3*N-1:0] cur_sig;
    int             cur_len;

    task automatic step(input logic [N-1:0] b, input logic mf);
        logic [N-1:0]   one;
        logic [N-1:0]   eg;
        logic [N-1:0]   ey;
        logic [N-1:0]   er;
        logic [3*N-1:0] sig;
        btn        = b;
        mode_flash = mf;
        @(posedge clk);
        model_edge(b, mf);
        #1;
        one = '0;
        one[m_ph] = 1'b1;
        eg = (m_st == S_GREEN) ? one : '0;
        if (m_st == S_YELLOW) ey = one;
        else if (m_st == S_FLASH && ((m_done / TF) % 2) == 0) ey = '1;
        else ey = '0;
        er = (m_st == S_FLASH) ? '0 : ~(eg | ey);
        chk("green", 32'(green), 32'(eg));
        chk("yellow", 32'(yellow), 32'(ey));
        chk("red", 32'(red), 32'(er));
        chk("phase", 32'(phase), 32'(m_ph));
        chk("green_onehot0", 32'($onehot0(green)), 32'd1);
        chk("green_yellow_excl", 32'(|(green & yellow)), 32'd0);
        sig = {green, yellow, red};
        if (sig == cur_sig) cur_len++;
        else begin
            run_len.push_back(cur_len);
            cur_sig = sig;
            cur_len = 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; lamps must react before any edge.
    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        chk("rst_red", 32'(red), 32'({N{1'b1}}));
        chk("rst_green", 32'(green), 32'd0);
        chk("rst_yellow", 32'(yellow), 32'd0);
        chk("rst_phase", 32'(phase), 32'(N - 1));
        model_reset();
        btn        = '0;
        mode_flash = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_len.delete();
        cur_sig = {{N{1'b0}}, {N{1'b0}}, {N{1'b1}}};
        cur_len = 1;
    endtask

    task automatic chk_run(input string tag, input int idx, input int exp);
        chk(tag, (idx < run_len.size()) ? 32'(run_len[idx]) : 32'hffff_ffff, 32'(exp));
    endtask

    int exp_basic [7] = '{2, 20, 11, 2, 20, 11, 2};

    initial begin
        logic         mf_r;
        logic [N-1:0] b_r;

        // Plain round-robin with no requests.
        do_reset();
        idle(68);
        for (int i = 0; i < 7; i++) chk_run($sformatf("basic_run%0d", i), i, exp_basic[i]);
        chk("basic_back_to_g0", 32'(green), 32'(N'(1)));

        // Request from approach 1 early in green 0: green cut to the minimum;
        // the latch is consumed so the following green 0 runs full length.
        do_reset();
        idle(4);
        step(N'(2), 1'b0);
        idle(73);
        chk_run("req_early_g0", 1, 10);
        chk_run("req_early_y0", 2, 11);
        chk_run("req_early_g1", 4, 20);
        chk_run("req_early_g0_again", 7, 20);

        // Request late in green 0 ends green on the following cycle.
        do_reset();
        idle(16);
        step(N'(2), 1'b0);
        idle(20);
        chk_run("req_late_g0", 1, 16);

        // Own-approach button while green is ignored.
        do_reset();
        idle(4);
        step(N'(1), 1'b0);
        idle(30);
        chk_run("req_own_g0", 1, 20);

        // Flash mode requested at green 1 cycle 5.
        do_reset();
        idle(39);
        repeat (45) step('0, 1'b1);
        idle(3);
        chk_run("flash_g1", 4, 5);
        chk_run("flash_y1", 5, 11);
        chk_run("flash_ar", 6, 2);
        chk_run("flash_on0", 7, 8);
        chk_run("flash_off0", 8, 8);
        chk_run("flash_on1", 9, 8);
        chk_run("flash_off1", 10, 8);
        chk_run("flash_exit_ar", 11, 2);
        chk("flash_exit_g0", 32'(green), 32'(N'(1)));

        // Reset in the middle of yellow 0.
        do_reset();
        idle(26);
        chk("mid_yellow_state", 32'(yellow), 32'(N'(1)));
        do_reset();
        idle(2);
        chk_run("post_rst_ar", 0, 2);
        chk("post_rst_g0", 32'(green), 32'(N'(1)));

        // Randomized buttons and flash mode, with one reset along the way.
        do_reset();
        mf_r = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 59) == 0) mf_r = ~mf_r;
            for (int i = 0; i < N; i++) b_r[i] = ($urandom_range(0, 15) == 0);
            step(b_r, mf_r);
            if (k == 700) begin
                do_reset();
                mf_r = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
